// File: rtl/epmp_mem_arbiter.sv
// Two-port memory bus arbiter: the CPU (MAR/MDR path) and the debug host share one wait-stated memory port.
// Optional debug starvation guard is compiled in with `define EPMP_ARB_STARVE_GUARD_EN.
module epmp_mem_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int WAIT_CYCLES  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Handshake: each requester holds a level request until its one-cycle ack and
    // drops it in the cycle after; requests are only looked at while in IDLE, so a
    // request still high when the arbiter is back in IDLE starts a new access.
    state_t state;
    state_t state_next;

    logic              owner_dbg;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [CNT_W-1:0]  wait_cnt;

    logic cpu_req;
    logic guard_trip;
    logic grant_cpu;
    logic grant_dbg;

    assign cpu_req = cpu_read | cpu_write;

    always_ff @(posedge clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_cpu  = 1'b0;
        grant_dbg  = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        cpu_ack    = 1'b0;
        dbg_ack    = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req && !guard_trip) begin
                    grant_cpu  = 1'b1;
                    state_next = ACCESS;
                end else if (dbg_req) begin
                    grant_dbg  = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                busy      = 1'b1;
                mem_en    = 1'b1;
                mem_we    = lat_we;
                mem_addr  = lat_addr;
                mem_wdata = lat_wdata;
                if (wait_cnt == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                cpu_ack    = !owner_dbg;
                dbg_ack    = owner_dbg;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Access registers: the memory port sees only the values captured at grant time.
    always_ff @(posedge clk) begin
        if (Reset) begin
            owner_dbg <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            wait_cnt  <= '0;
            rd_data   <= '0;
        end else begin
            if (grant_cpu) begin
                owner_dbg <= 1'b0;
                lat_we    <= cpu_write;
                lat_addr  <= cpu_addr;
                lat_wdata <= cpu_wdata;
                wait_cnt  <= CNT_W'(WAIT_CYCLES);
            end else if (grant_dbg) begin
                owner_dbg <= 1'b1;
                lat_we    <= dbg_we;
                lat_addr  <= dbg_addr;
                lat_wdata <= dbg_wdata;
                wait_cnt  <= CNT_W'(WAIT_CYCLES);
            end
            if (state == ACCESS) begin
                if (wait_cnt == '0) begin
                    if (!lat_we) begin
                        rd_data <= mem_rdata;
                    end
                end else begin
                    wait_cnt <= wait_cnt - CNT_W'(1);
                end
            end
        end
    end

`ifdef EPMP_ARB_STARVE_GUARD_EN
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);

    logic [SC_W-1:0] starve_cnt;

    // Counts CPU grants taken while debug was waiting; debug wins once it reaches the limit.
    always_ff @(posedge clk) begin
        if (Reset) begin
            starve_cnt <= '0;
        end else if (grant_dbg) begin
            starve_cnt <= '0;
        end else if (state == IDLE && !dbg_req) begin
            starve_cnt <= '0;
        end else if (grant_cpu && dbg_req) begin
            starve_cnt <= starve_cnt + SC_W'(1);
        end
    end

    assign guard_trip = (starve_cnt == SC_W'(STARVE_LIMIT));
`else
    assign guard_trip = 1'b0;
`endif

endmodule

// File: tb/tb_epmp_mem_arbiter.sv
// Self-checking bench for epmp_mem_arbiter: directed timing cases plus randomized two-requester traffic
// scored against a per-requester expected queue and a shadow memory.
module tb_epmp_mem_arbiter;

    localparam int ADDR_W       = 8;
    localparam int DATA_W       = 8;
    localparam int WAIT_CYCLES  = 2;
    localparam int STARVE_LIMIT = 4;
    localparam int TO           = 300;

    logic              clk = 1'b0;
    logic              Reset = 1'b1;
    logic              cpu_read = 1'b0;
    logic              cpu_write = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              cpu_ack;
    logic              dbg_req = 1'b0;
    logic              dbg_we = 1'b0;
    logic [ADDR_W-1:0] dbg_addr = '0;
    logic [DATA_W-1:0] dbg_wdata = '0;
    logic              dbg_ack;
    logic [DATA_W-1:0] rd_data;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    // clock / reset
    always #5 clk = ~clk;

    epmp_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(WAIT_CYCLES), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .Reset(Reset),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack),
        .rd_data(rd_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    // external memory: unwritten locations read as addr ^ 0xB5 (so 0x10 holds 0xA5)
    logic [7:0] tb_mem [256];
    bit         tb_vld [256];

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            tb_mem[mem_addr] <= mem_wdata;
            tb_vld[mem_addr] <= 1'b1;
        end
    end

    always_comb begin
        if (!mem_en)                mem_rdata = 8'h00;
        else if (tb_vld[mem_addr])  mem_rdata = tb_mem[mem_addr];
        else                        mem_rdata = mem_addr ^ 8'hB5;
    end

    function automatic logic [7:0] mem_peek(input logic [7:0] a);
        if (tb_vld[a]) return tb_mem[a];
        return a ^ 8'hB5;
    endfunction

    // scoreboard state: {we, addr, wdata}
    int          total = 0;
    int          bad = 0;
    logic [16:0] cpu_exp_q [$];
    logic [16:0] dbg_exp_q [$];
    logic [7:0]  shadow [256];
    logic [7:0]  last_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic score(input logic [16:0] e);
        logic [7:0] a;
        logic [7:0] d;
        a = e[15:8];
        d = e[7:0];
        if (e[16]) begin
            check("write_mem", 32'(mem_peek(a)), 32'(d));
            check("rd_hold", 32'(rd_data), 32'(last_rd));
            shadow[a] = d;
        end else begin
            check("read_data", 32'(rd_data), 32'(shadow[a]));
            last_rd = shadow[a];
        end
    endtask

    // monitor: pops the owner's expected entry on every ack
    always @(negedge clk) begin : monitor
        logic [16:0] e;
        if (cpu_ack || dbg_ack) begin
            check("ack_exclusive", 32'(cpu_ack & dbg_ack), 32'(0));
            if (cpu_ack) begin
                check("cpu_q_nonempty", 32'(cpu_exp_q.size() != 0), 32'(1));
                if (cpu_exp_q.size() != 0) begin
                    e = cpu_exp_q.pop_front();
                    score(e);
                end
            end else begin
                check("dbg_q_nonempty", 32'(dbg_exp_q.size() != 0), 32'(1));
                if (dbg_exp_q.size() != 0) begin
                    e = dbg_exp_q.pop_front();
                    score(e);
                end
            end
        end
    end

    // driver tasks (all input changes at posedge + 1)
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ack(input bit is_dbg);
        int n;
        n = 0;
        @(negedge clk);
        while (!(is_dbg ? dbg_ack : cpu_ack) && n < TO) begin
            @(negedge clk);
            n++;
        end
        if (is_dbg) check("dbg_ack_wait", 32'(n >= TO), 32'(0));
        else        check("cpu_ack_wait", 32'(n >= TO), 32'(0));
        @(posedge clk);
        #1;
    endtask

    // Cycle-accurate watch; cycle 0 is the cycle the requests were raised in.
    task automatic watch(input string tag, input int n, input int cpu_at, input int dbg_at,
                         input int a1, input int b1, input logic we1, input logic [7:0] ad1,
                         input int a2, input int b2, input logic we2, input logic [7:0] ad2);
        bit drop_c;
        bit drop_d;
        bit in1;
        bit in2;
        drop_c = 1'b0;
        drop_d = 1'b0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                cpu_addr  = 8'($urandom);
                cpu_wdata = 8'($urandom);
            end
            if (drop_c) begin
                cpu_read  = 1'b0;
                cpu_write = 1'b0;
            end
            if (drop_d) dbg_req = 1'b0;
            @(negedge clk);
            in1 = (k >= a1) && (k <= b1);
            in2 = (k >= a2) && (k <= b2);
            check({tag, "_cpu_ack"}, 32'(cpu_ack), 32'(k == cpu_at));
            check({tag, "_dbg_ack"}, 32'(dbg_ack), 32'(k == dbg_at));
            check({tag, "_mem_en"}, 32'(mem_en), 32'(in1 || in2));
            check({tag, "_busy"}, 32'(busy), 32'(in1 || in2 || k == cpu_at || k == dbg_at));
            if (in1) begin
                check({tag, "_mem_we"}, 32'(mem_we), 32'(we1));
                check({tag, "_mem_addr"}, 32'(mem_addr), 32'(ad1));
            end
            if (in2) begin
                check({tag, "_mem_we2"}, 32'(mem_we), 32'(we2));
                check({tag, "_mem_addr2"}, 32'(mem_addr), 32'(ad2));
            end
            drop_c = cpu_ack;
            drop_d = dbg_ack;
        end
    endtask

    task automatic cpu_drv(input int n);
        int         kind;
        logic [7:0] a;
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            idle($urandom_range(0, 3));
            kind = $urandom_range(0, 2);
            a = 8'($urandom_range(0, 'h6F));
            d = 8'($urandom);
            cpu_exp_q.push_back({kind != 0, a, d});
            cpu_addr  = a;
            cpu_wdata = d;
            cpu_read  = (kind != 1);
            cpu_write = (kind != 0);
            wait_ack(1'b0);
            cpu_read  = 1'b0;
            cpu_write = 1'b0;
        end
    endtask

    task automatic dbg_drv(input int n);
        bit         we;
        logic [7:0] a;
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            idle($urandom_range(0, 4));
            we = 1'($urandom_range(0, 1));
            a = 8'($urandom_range('h80, 'hFF));
            d = 8'($urandom);
            dbg_exp_q.push_back({we, a, d});
            dbg_addr  = a;
            dbg_wdata = d;
            dbg_we    = we;
            dbg_req   = 1'b1;
            wait_ack(1'b1);
            dbg_req = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp_seq [10];
        bit pending;
        int scnt;
        int ncpu;
        int n;
        bit got_d;

        for (int i = 0; i < 256; i++) shadow[i] = 8'(i) ^ 8'hB5;
        last_rd = 8'h00;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_en", 32'(mem_en), 32'(0));
        check("rst_mem_we", 32'(mem_we), 32'(0));
        check("rst_mem_addr", 32'(mem_addr), 32'(0));
        check("rst_mem_wdata", 32'(mem_wdata), 32'(0));
        check("rst_cpu_ack", 32'(cpu_ack), 32'(0));
        check("rst_dbg_ack", 32'(dbg_ack), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_rd_data", 32'(rd_data), 32'(0));
        @(posedge clk);
        #1;
        Reset = 1'b0;
        idle(2);

        // single CPU read of 0x10
        cpu_exp_q.push_back({1'b0, 8'h10, 8'h00});
        cpu_addr = 8'h10;
        cpu_read = 1'b1;
        watch("rd", 6, 4, 0, 1, 3, 1'b0, 8'h10, 0, -1, 1'b0, 8'h00);
        check("rd_value", 32'(rd_data), 32'(8'hA5));
        idle(2);

        // debug write 0x5A to 0x3C
        dbg_exp_q.push_back({1'b1, 8'h3C, 8'h5A});
        dbg_addr  = 8'h3C;
        dbg_wdata = 8'h5A;
        dbg_we    = 1'b1;
        dbg_req   = 1'b1;
        watch("dw", 6, 0, 4, 1, 3, 1'b1, 8'h3C, 0, -1, 1'b0, 8'h00);
        check("dw_rd_unchanged", 32'(rd_data), 32'(8'hA5));
        idle(2);

        // simultaneous requests: CPU first, debug granted in cycle 5
        cpu_exp_q.push_back({1'b0, 8'h20, 8'h00});
        dbg_exp_q.push_back({1'b0, 8'h90, 8'h00});
        cpu_addr = 8'h20;
        cpu_read = 1'b1;
        dbg_addr = 8'h90;
        dbg_we   = 1'b0;
        dbg_req  = 1'b1;
        watch("arb", 11, 4, 9, 1, 3, 1'b0, 8'h20, 6, 8, 1'b0, 8'h90);
        idle(2);

        // read and write together perform a write
        cpu_exp_q.push_back({1'b1, 8'h30, 8'h77});
        cpu_addr  = 8'h30;
        cpu_wdata = 8'h77;
        cpu_read  = 1'b1;
        cpu_write = 1'b1;
        watch("both", 6, 4, 0, 1, 3, 1'b1, 8'h30, 0, -1, 1'b0, 8'h00);
        idle(2);

        // continuous CPU reads with debug pending: expected ack order from the priority rule
        pending = 1'b1;
        scnt = 0;
        for (int i = 0; i < 10; i++) begin
            exp_seq[i] = 1'b0;
`ifdef EPMP_ARB_STARVE_GUARD_EN
            if (pending && scnt == STARVE_LIMIT) begin
                exp_seq[i] = 1'b1;
                pending = 1'b0;
                scnt = 0;
            end else if (pending) begin
                scnt++;
            end
`endif
        end
        ncpu = 0;
        for (int i = 0; i < 10; i++) if (!exp_seq[i]) ncpu++;
        repeat (ncpu) cpu_exp_q.push_back({1'b0, 8'h40, 8'h00});
        dbg_exp_q.push_back({1'b0, 8'hA0, 8'h00});
        cpu_addr = 8'h40;
        cpu_read = 1'b1;
        dbg_addr = 8'hA0;
        dbg_we   = 1'b0;
        dbg_req  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(cpu_ack || dbg_ack) && n < TO);
            check("starve_wait", 32'(n >= TO), 32'(0));
            got_d = dbg_ack;
            check("starve_order", 32'(got_d), 32'(exp_seq[i]));
            @(posedge clk);
            #1;
            if (got_d) dbg_req = 1'b0;
            if (i == 9) cpu_read = 1'b0;
        end
        if (dbg_req) begin
            wait_ack(1'b1);
            dbg_req = 1'b0;
        end
        idle(2);

        // reset during the second ACCESS cycle of a CPU write
        cpu_addr  = 8'h70;
        cpu_wdata = 8'h99;
        cpu_write = 1'b1;
        idle(2);
        Reset = 1'b1;
        idle(1);
        Reset = 1'b0;
        cpu_write = 1'b0;
        @(negedge clk);
        check("rst_abort_mem_en", 32'(mem_en), 32'(0));
        check("rst_abort_mem_we", 32'(mem_we), 32'(0));
        check("rst_abort_busy", 32'(busy), 32'(0));
        check("rst_abort_ack", 32'(cpu_ack), 32'(0));
        check("rst_abort_rd_data", 32'(rd_data), 32'(0));
        last_rd = 8'h00;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("rst_abort_no_ack", 32'(cpu_ack | dbg_ack), 32'(0));
        end
        idle(1);

        // randomized two-requester traffic
        fork
            cpu_drv(40);
            dbg_drv(30);
        join
        idle(6);

        check("cpu_q_empty", 32'(cpu_exp_q.size()), 32'(0));
        check("dbg_q_empty", 32'(dbg_exp_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/epmp_mem_arbiter.md
# epmp_mem_arbiter

Two-port memory bus arbiter for the EPMP processor. Shares one synchronous external memory port between the CPU control unit (the instruction and data read/write cycles issued through the MAR/MDR path) and a debug host port used for memory inspection and patching while the core is stepped. Each access is one fixed-length, wait-stated memory transaction. The CPU has priority, and an optional starvation guard bounds how long the debug port waits.

## Interface
- ADDR_W, 8, address width of both requesters and the memory port
- DATA_W, 8, data width
- WAIT_CYCLES, 2, memory wait states; must be ≥ 0; each access holds the memory port for WAIT_CYCLES+1 cycles
- STARVE_LIMIT, 4, consecutive CPU grants tolerated while debug is pending (used only with the guard compiled in); must be ≥ 1
- clk  in  1  system clock; all state changes on the rising edge
- Reset  in  1  synchronous, active-high reset
- cpu_read  in  1  CPU read request, level, held until cpu_ack
- cpu_write  in  1  CPU write request, level, held until cpu_ack
- cpu_addr  in  ADDR_W  CPU address (MAR)
- cpu_wdata  in  DATA_W  CPU write data (MDR)
- cpu_ack  out  1  one-cycle completion pulse to the CPU
- dbg_req  in  1  debug request, level, held until dbg_ack
- dbg_we  in  1  1 = write, 0 = read; qualifies dbg_req
- dbg_addr  in  ADDR_W  debug address
- dbg_wdata  in  DATA_W  debug write data
- dbg_ack  out  1  one-cycle completion pulse to debug
- rd_data  out  DATA_W  read data register; valid in the ack cycle, held until the next read completes
- mem_en  out  1  memory port enable
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid in the last enabled cycle of an access
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, ACCESS, DONE. Reset forces IDLE.
- Reset values: all outputs 0, rd_data = 0, wait counter = 0, starve counter = 0.
- IDLE arbitration, evaluated each cycle:
  - If a CPU request is present (cpu_read | cpu_write) and the guard is not tripped, grant the CPU.
  - Otherwise, if dbg_req is high, grant debug.
  - Otherwise, stay in IDLE.
- On a grant:
  - Latch owner, address, write data and the write flag into internal registers.
  - Move to ACCESS and load the wait counter with WAIT_CYCLES.
- CPU write flag = cpu_write. If cpu_read and cpu_write are both high, the access is a write.
- ACCESS:
  - mem_en = 1; mem_we, mem_addr and mem_wdata come from the latched registers, stable for the whole access.
  - The counter decrements each cycle.
  - When the counter is 0, capture mem_rdata into rd_data (reads only) and go to DONE.
- DONE: assert the owner's ack for exactly one cycle, mem_en = 0, next state IDLE.
- Request inputs are ignored outside IDLE. Changes to address or data after the grant have no effect.
- Requesters drop their request in the cycle after ack. A request still high in IDLE is treated as a new access.
- Write accesses leave rd_data unchanged.

## Timing
- Request first sampled high in IDLE at edge 0.
- ACCESS occupies cycles 1 to WAIT_CYCLES+1.
- ack is high in cycle WAIT_CYCLES+2, and the arbiter is back in IDLE at cycle WAIT_CYCLES+3.
- Minimum request-to-ack latency is WAIT_CYCLES+2 cycles. Back-to-back throughput is one access per WAIT_CYCLES+3 cycles.
- Simultaneous CPU and debug requests in IDLE: the CPU wins unless the starvation guard is tripped.
- Reset in ACCESS or DONE:
  - Abort immediately and return to IDLE the next cycle.
  - No ack is issued; mem_en and mem_we are 0 from the cycle after Reset is sampled.
  - rd_data is cleared to 0.

## Configuration
- EPMP_ARB_STARVE_GUARD_EN defined:
  - A starve counter increments on each CPU grant made while dbg_req is high.
  - It clears on a debug grant, or in any IDLE cycle where dbg_req is low.
  - When the counter equals STARVE_LIMIT, the guard is tripped and the next IDLE arbitration grants debug even if the CPU is requesting.
- Not defined: strict CPU priority, no counter logic; debug is served only when the CPU is idle.

## Test plan
- Single CPU read: WAIT_CYCLES=2, memory returns 0xA5 at addr 0x10, cpu_read high at cycle 0 -> mem_en high in cycles 1-3 with mem_addr=0x10, cpu_ack high in cycle 4 only, rd_data=0xA5.
- Debug write to 0x3C with data 0x5A, CPU idle -> mem_we high in cycles 1-3, dbg_ack high in cycle 4, rd_data unchanged, cpu_ack never asserted.
- CPU and debug requests raised in the same cycle -> the CPU access completes first (cpu_ack in cycle 4), debug is granted in cycle 5, dbg_ack in cycle 9.
- Guard compiled in, STARVE_LIMIT=4, CPU requesting continuously with dbg_req high -> exactly 4 CPU acks, then 1 dbg_ack, then CPU service resumes. Without the macro -> no dbg_ack while the CPU keeps requesting.
- Reset asserted in the second ACCESS cycle of a CPU write -> no cpu_ack, mem_en=0 from the next cycle, state IDLE, busy=0.
- cpu_read and cpu_write both high -> a write is performed (mem_we=1) and rd_data keeps its previous value.
